// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Shared definitions for the 8-bit PWM generator and its
//             sequencing controllers (duty width, period length, ramp FSM
//             state encoding, and the saturating duty-step helper).
//  Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

    localparam int DUTY_W       = 8;
    localparam int PERIOD_TICKS = 256;

    // Ramp controller state encoding (2-bit).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } ramp_state_t;

    // One ramp step from cur toward tgt by stp, clamped at tgt.
    // Arithmetic is carried in DUTY_W+1 bits so neither the sum can wrap
    // past full scale nor the difference underflow below zero.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] stp
    );
        logic [DUTY_W:0]   sum;
        logic [DUTY_W:0]   diff;
        logic [DUTY_W-1:0] res;
        sum  = {1'b0, cur} + {1'b0, stp};
        diff = {1'b0, cur} - {1'b0, stp};
        res  = cur;
        if (cur < tgt) begin
            res = (sum >= {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
        end else if (cur > tgt) begin
            // diff MSB set means cur-stp went negative.
            res = (diff[DUTY_W] || (diff[DUTY_W-1:0] <= tgt)) ? tgt : diff[DUTY_W-1:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_ctrl_if
//  Purpose  : Request/status bundle between a sequencer (master) and the
//             PWM ramp controller (slave).
//  Signals  : start/target/step/hold  - ramp request (master -> slave)
//             clken/duty/period_end   - drive for one pwm instance
//             busy/done               - ramp status
//  Revision : 1.0  initial release
// ============================================================================
interface pwm_ramp_ctrl_if;
    import pwm_pkg::*;

    logic              start;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] step;
    logic [DUTY_W-1:0] hold;
    logic              clken;
    logic [DUTY_W-1:0] duty;
    logic              period_end;
    logic              busy;
    logic              done;

    modport master (
        output start, target, step, hold,
        input  clken, duty, period_end, busy, done
    );

    modport slave (
        input  start, target, step, hold,
        output clken, duty, period_end, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_prescaler
//  Purpose  : Divides clk down to a one-cycle clken pulse every DIV cycles.
//             The first pulse appears after the DIV-th edge following reset.
//  Ports    : clk   - system clock
//             rst   - synchronous active-high reset
//             clken - registered one-cycle enable pulse
//  Revision : 1.0  initial release
// ============================================================================
module pwm_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clken
);

    localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_pre_cnt;
    logic               r_clken;

    // With DIV=1 c_LAST is 0, so the counter idles at 0 and clken
    // stays high on every cycle after the first post-reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_clken   <= 1'b0;
        end else if (r_pre_cnt == c_LAST) begin
            r_pre_cnt <= '0;
            r_clken   <= 1'b1;
        end else begin
            r_pre_cnt <= r_pre_cnt + c_CNT_W'(1);
            r_clken   <= 1'b0;
        end
    end

    assign clken = r_clken;

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ramp_ctrl
//  Purpose  : Sequences one 8-bit pwm instance: generates its clken, tracks
//             the 256-tick period phase, and ramps duty toward a requested
//             target in programmable steps, changing duty only on period
//             boundaries so no PWM period is truncated.
//  Ports    : clk  - system clock
//             rst  - synchronous active-high reset
//             bus  - pwm_ramp_ctrl_if.slave (start/target/step/hold in;
//                    clken/duty/period_end/busy/done out)
//  Params   : DIV       - clk cycles per clken pulse (1..65535)
//             INIT_DUTY - duty driven after reset
//  Revision : 1.0  initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int                DIV       = 4,
    parameter logic [DUTY_W-1:0] INIT_DUTY = '0
) (
    input  logic            clk,
    input  logic            rst,
    pwm_ramp_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // Prescaler and period tracker
    // ------------------------------------------------------------------
    logic              w_clken;
    logic [DUTY_W-1:0] r_tick_cnt;
    logic              w_period_end;

    pwm_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clken (w_clken)
    );

    // Mirrors the pwm's internal tick counter; both start at 0 from reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_clken) begin
            r_tick_cnt <= r_tick_cnt + DUTY_W'(1);
        end
    end

    assign w_period_end = w_clken & (r_tick_cnt == DUTY_W'(PERIOD_TICKS - 1));

    // ------------------------------------------------------------------
    // Ramp FSM
    // ------------------------------------------------------------------
    ramp_state_t       r_state,    w_state_nxt;
    logic [DUTY_W-1:0] r_duty,     w_duty_nxt;
    logic [DUTY_W-1:0] r_target,   w_target_nxt;
    logic [DUTY_W-1:0] r_step,     w_step_nxt;
    logic [DUTY_W-1:0] r_hold,     w_hold_nxt;
    logic [DUTY_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [DUTY_W-1:0] w_duty_upd;
    logic [DUTY_W-1:0] w_hold_dec;
    logic [DUTY_W-1:0] w_req_step;
    logic [DUTY_W-1:0] w_req_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_duty     <= INIT_DUTY;
            r_target   <= '0;
            r_step     <= '0;
            r_hold     <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_target   <= w_target_nxt;
            r_step     <= w_step_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // A zero step or hold would stall the ramp forever; both mean 1.
    assign w_req_step = (bus.step == '0) ? DUTY_W'(1) : bus.step;
    assign w_req_hold = (bus.hold == '0) ? DUTY_W'(1) : bus.hold;
    assign w_duty_upd = ramp_next(r_duty, r_target, r_step);
    assign w_hold_dec = r_hold_cnt - DUTY_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_target_nxt   = r_target;
        w_step_nxt     = r_step;
        w_hold_nxt     = r_hold;
        w_hold_cnt_nxt = r_hold_cnt;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_target_nxt   = bus.target;
                    w_step_nxt     = w_req_step;
                    w_hold_nxt     = w_req_hold;
                    // The partially elapsed current period counts as one.
                    w_hold_cnt_nxt = w_req_hold;
                    w_state_nxt    = (bus.target == r_duty) ? ST_DONE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                // Duty only moves on the last tick of a period, so the new
                // value takes effect from tick 0 of the following period.
                if (w_period_end) begin
                    if (w_hold_dec == '0) begin
                        w_hold_cnt_nxt = r_hold;
                        w_duty_nxt     = w_duty_upd;
                        if (w_duty_upd == r_target) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_hold_cnt_nxt = w_hold_dec;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.clken      = w_clken;
    assign bus.duty       = r_duty;
    assign bus.period_end = w_period_end;
    assign bus.busy       = (r_state == ST_RAMP);
    assign bus.done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_ramp_ctrl
//  Purpose  : Self-checking bench for pwm_ramp_ctrl. A DIV=1 instance is
//             driven with directed and random ramps and compared every
//             cycle against a queue-based reference model; a DIV=4
//             instance checks prescaler and period timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_ramp_ctrl_if bus1();
    pwm_ramp_ctrl_if bus4();

    pwm_ramp_ctrl #(.DIV(1), .INIT_DUTY(8'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    pwm_ramp_ctrl #(.DIV(4), .INIT_DUTY(8'd0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release, current duty,
    // phase, and the queue of duty values still to be applied.
    int m_k;
    int m_duty;
    int m_phase;
    int m_left;
    int m_hold;
    int m_q[$];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)", tag, got, exp, m_k, $time);
        end
    endtask

    // Advance the model across the coming clock edge using current inputs.
    task automatic model_advance();
        int t, s, h, d;
        if (rst) begin
            m_k = 0; m_duty = 0; m_phase = M_IDLE; m_left = 0; m_q.delete();
        end else begin
            case (m_phase)
                M_IDLE: if (bus1.start) begin
                    t = int'(bus1.target);
                    s = (bus1.step == 8'd0) ? 1 : int'(bus1.step);
                    h = (bus1.hold == 8'd0) ? 1 : int'(bus1.hold);
                    m_hold = h; m_left = h; m_q.delete();
                    d = m_duty;
                    while (d != t) begin
                        if (d < t) d = (d + s > t) ? t : d + s;
                        else       d = (d - s < t) ? t : d - s;
                        m_q.push_back(d);
                    end
                    m_phase = (m_q.size() == 0) ? M_DONE : M_RAMP;
                end
                M_RAMP: if (m_k > 0 && m_k % 256 == 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_duty = m_q.pop_front();
                        m_left = m_hold;
                        if (m_q.size() == 0) m_phase = M_DONE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
            m_k++;
        end
    endtask

    task automatic step_clk();
        model_advance();
        @(posedge clk);
        #1;
        check_val("duty",       int'(bus1.duty),       m_duty);
        check_val("busy",       int'(bus1.busy),       (m_phase == M_RAMP) ? 1 : 0);
        check_val("done",       int'(bus1.done),       (m_phase == M_DONE) ? 1 : 0);
        check_val("clken",      int'(bus1.clken),      (m_k >= 1) ? 1 : 0);
        check_val("period_end", int'(bus1.period_end), (m_k > 0 && m_k % 256 == 0) ? 1 : 0);
        check_val("clken4",     int'(bus4.clken),      (m_k > 0 && m_k % 4 == 0) ? 1 : 0);
        check_val("period_end4",int'(bus4.period_end), (m_k > 0 && m_k % 1024 == 0) ? 1 : 0);
        check_val("duty4",      int'(bus4.duty),       0);
        check_val("busy4",      int'(bus4.busy),       0);
    endtask

    task automatic scramble();
        bus1.target = 8'($urandom_range(0, 255));
        bus1.step   = 8'($urandom_range(0, 255));
        bus1.hold   = 8'($urandom_range(0, 255));
    endtask

    task automatic do_start(input int t, input int s, input int h);
        bus1.start  = 1'b1;
        bus1.target = 8'(t);
        bus1.step   = 8'(s);
        bus1.hold   = 8'(h);
        step_clk();
        bus1.start  = 1'b0;
        scramble();
    endtask

    // Run until the DUT reports done (bounded), optionally poking start
    // during the ramp and in the done cycle, then step back to idle.
    task automatic run_ramp(input int budget, input bit noise);
        int n = 0;
        while (bus1.done !== 1'b1 && n < budget) begin
            bus1.start = noise && ($urandom_range(0, 31) == 0);
            if (noise) scramble();
            step_clk();
            n++;
        end
        check_val("done_seen", int'(bus1.done), 1);
        bus1.start = noise;
        step_clk();
        bus1.start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus1.start = 1'b0; bus1.target = '0; bus1.step = '0; bus1.hold = '0;
        bus4.start = 1'b0; bus4.target = '0; bus4.step = '0; bus4.hold = '0;

        // Reset held for three edges.
        repeat (3) step_clk();
        rst = 1'b0;

        // Up-ramp 0 -> 10, step 4, every period.
        do_start(10, 4, 1);
        run_ramp(4000, 1'b0);

        // Down-ramp 10 -> 0, step 5, every 2nd period.
        do_start(0, 5, 2);
        run_ramp(4000, 1'b0);

        // Ramp to 50 with a competing start mid-ramp; then a no-op start.
        do_start(50, 25, 1);
        repeat (100) step_clk();
        do_start(200, 1, 1);
        run_ramp(4000, 1'b0);
        do_start(50, 3, 3);
        run_ramp(10, 1'b0);

        // Saturation and zero step/hold.
        do_start(100, 100, 1);
        run_ramp(4000, 1'b0);
        do_start(255, 200, 0);
        run_ramp(4000, 1'b0);
        do_start(100, 155, 1);
        run_ramp(4000, 1'b0);
        do_start(102, 0, 1);
        run_ramp(4000, 1'b0);

        // Reset mid-ramp at duty 8, then a fresh ramp.
        do_start(0, 255, 1);
        run_ramp(4000, 1'b0);
        do_start(40, 4, 1);
        n = 0;
        while (m_duty != 8 && n < 4000) begin step_clk(); n++; end
        check_val("reached_8", int'(bus1.duty), 8);
        repeat (20) step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        repeat (5) step_clk();
        do_start(12, 4, 1);
        run_ramp(4000, 1'b0);

        // Random ramps with input noise during the ramp and done cycle.
        for (int i = 0; i < 6; i++) begin
            do_start($urandom_range(0, 255), $urandom_range(32, 255), $urandom_range(0, 2));
            run_ramp(20000, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
